id_ex_stage: RTL and testbench

- ID/EX pipeline register directly upstream of the execute ALU.
- Captures decoded operands and control from ID and drives the ALU operand/control inputs (din1, dreg, dext, alusrc, aluctrl).
- Applies EX/MEM and MEM/WB operand forwarding combinationally on the registered operands.
- Detects load-use hazards, requests an upstream freeze, and inserts bubbles on hazard or flush.

---
 rtl/id_ex_stage.sv | 180 ++++++++++++++++++
 tb/tb_id_ex_stage.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ============================================================================
//  Module   : id_ex_stage
//  Brief    : ID/EX pipeline register with EX/MEM and MEM/WB operand
//             forwarding, load-use hazard detection and bubble insertion.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_ex_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          flush,
    input  logic          id_valid,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic [RW-1:0] id_rd,
    input  logic [DW-1:0] id_rdata1,
    input  logic [DW-1:0] id_rdata2,
    input  logic [DW-1:0] id_imm,
    input  logic          id_alusrc,
    input  logic [2:0]    id_aluctrl,
    input  logic          id_regwrite,
    input  logic          id_memread,
    input  logic          id_memwrite,
    input  logic          id_memtoreg,
    input  logic          mem_regwrite,
    input  logic [RW-1:0] mem_rd,
    input  logic [DW-1:0] mem_result,
    input  logic          wb_regwrite,
    input  logic [RW-1:0] wb_rd,
    input  logic [DW-1:0] wb_result,
    output logic          hazard_stall,
    output logic          ex_valid,
    output logic [DW-1:0] din1,
    output logic [DW-1:0] dreg,
    output logic [DW-1:0] dext,
    output logic          alusrc,
    output logic [2:0]    aluctrl,
    output logic [RW-1:0] ex_rd,
    output logic          ex_regwrite,
    output logic          ex_memread,
    output logic          ex_memwrite,
    output logic          ex_memtoreg
);

    localparam logic [2:0] C_ALU_ADD = 3'h2;

    logic          valid_q,    valid_d;
    logic [RW-1:0] rs_q,       rs_d;
    logic [RW-1:0] rt_q,       rt_d;
    logic [RW-1:0] rd_q,       rd_d;
    logic [DW-1:0] rdata1_q,   rdata1_d;
    logic [DW-1:0] rdata2_q,   rdata2_d;
    logic [DW-1:0] imm_q,      imm_d;
    logic          alusrc_q,   alusrc_d;
    logic [2:0]    aluctrl_q,  aluctrl_d;
    logic          regwrite_q, regwrite_d;
    logic          memread_q,  memread_d;
    logic          memwrite_q, memwrite_d;
    logic          memtoreg_q, memtoreg_d;

    // The rt match is checked even for instructions that do not read rt.
    assign hazard_stall = valid_q && memread_q && (rd_q != '0) && id_valid &&
                          ((rd_q == id_rs) || (rd_q == id_rt));

    always_comb begin
        valid_d    = valid_q;
        rs_d       = rs_q;
        rt_d       = rt_q;
        rd_d       = rd_q;
        rdata1_d   = rdata1_q;
        rdata2_d   = rdata2_q;
        imm_d      = imm_q;
        alusrc_d   = alusrc_q;
        aluctrl_d  = aluctrl_q;
        regwrite_d = regwrite_q;
        memread_d  = memread_q;
        memwrite_d = memwrite_q;
        memtoreg_d = memtoreg_q;
        if (!stall) begin
            if (flush || hazard_stall) begin
                valid_d    = 1'b0;
                rs_d       = '0;
                rt_d       = '0;
                rd_d       = '0;
                rdata1_d   = '0;
                rdata2_d   = '0;
                imm_d      = '0;
                alusrc_d   = 1'b0;
                aluctrl_d  = C_ALU_ADD;
                regwrite_d = 1'b0;
                memread_d  = 1'b0;
                memwrite_d = 1'b0;
                memtoreg_d = 1'b0;
            end else begin
                valid_d    = id_valid;
                rs_d       = id_rs;
                rt_d       = id_rt;
                rd_d       = id_rd;
                rdata1_d   = id_rdata1;
                rdata2_d   = id_rdata2;
                imm_d      = id_imm;
                alusrc_d   = id_alusrc;
                aluctrl_d  = id_aluctrl;
                regwrite_d = id_regwrite;
                memread_d  = id_memread;
                memwrite_d = id_memwrite;
                memtoreg_d = id_memtoreg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            rs_q       <= '0;
            rt_q       <= '0;
            rd_q       <= '0;
            rdata1_q   <= '0;
            rdata2_q   <= '0;
            imm_q      <= '0;
            alusrc_q   <= 1'b0;
            aluctrl_q  <= C_ALU_ADD;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            rs_q       <= rs_d;
            rt_q       <= rt_d;
            rd_q       <= rd_d;
            rdata1_q   <= rdata1_d;
            rdata2_q   <= rdata2_d;
            imm_q      <= imm_d;
            alusrc_q   <= alusrc_d;
            aluctrl_q  <= aluctrl_d;
            regwrite_q <= regwrite_d;
            memread_q  <= memread_d;
            memwrite_q <= memwrite_d;
            memtoreg_q <= memtoreg_d;
        end
    end

    // EX/MEM wins over MEM/WB; index 0 always falls through to the register value.
    always_comb begin
        din1 = rdata1_q;
        if (mem_regwrite && (mem_rd != '0) && (mem_rd == rs_q)) begin
            din1 = mem_result;
        end else if (wb_regwrite && (wb_rd != '0) && (wb_rd == rs_q)) begin
            din1 = wb_result;
        end
    end

    always_comb begin
        dreg = rdata2_q;
        if (mem_regwrite && (mem_rd != '0) && (mem_rd == rt_q)) begin
            dreg = mem_result;
        end else if (wb_regwrite && (wb_rd != '0) && (wb_rd == rt_q)) begin
            dreg = wb_result;
        end
    end

    assign ex_valid    = valid_q;
    assign dext        = imm_q;
    assign alusrc      = alusrc_q;
    assign aluctrl     = aluctrl_q;
    assign ex_rd       = rd_q;
    assign ex_regwrite = regwrite_q;
    assign ex_memread  = memread_q;
    assign ex_memwrite = memwrite_q;
    assign ex_memtoreg = memtoreg_q;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// ============================================================================
//  Module   : tb_id_ex_stage
//  Brief    : Directed self-checking bench for id_ex_stage.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_ex_stage;

    localparam int DW = 32;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          rst, stall, flush, id_valid;
    logic [RW-1:0] id_rs, id_rt, id_rd;
    logic [DW-1:0] id_rdata1, id_rdata2, id_imm;
    logic          id_alusrc;
    logic [2:0]    id_aluctrl;
    logic          id_regwrite, id_memread, id_memwrite, id_memtoreg;
    logic          mem_regwrite;
    logic [RW-1:0] mem_rd;
    logic [DW-1:0] mem_result;
    logic          wb_regwrite;
    logic [RW-1:0] wb_rd;
    logic [DW-1:0] wb_result;
    logic          hazard_stall, ex_valid;
    logic [DW-1:0] din1, dreg, dext;
    logic          alusrc;
    logic [2:0]    aluctrl;
    logic [RW-1:0] ex_rd;
    logic          ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg;

    int n_checks = 0;
    int n_pass   = 0;

    id_ex_stage #(.DW(DW), .RW(RW)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
        .id_alusrc(id_alusrc), .id_aluctrl(id_aluctrl),
        .id_regwrite(id_regwrite), .id_memread(id_memread),
        .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg),
        .mem_regwrite(mem_regwrite), .mem_rd(mem_rd), .mem_result(mem_result),
        .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_result(wb_result),
        .hazard_stall(hazard_stall), .ex_valid(ex_valid),
        .din1(din1), .dreg(dreg), .dext(dext),
        .alusrc(alusrc), .aluctrl(aluctrl), .ex_rd(ex_rd),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic id_clear();
        id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0;
        id_rdata1 = 0; id_rdata2 = 0; id_imm = 0;
        id_alusrc = 0; id_aluctrl = 3'h2;
        id_regwrite = 0; id_memread = 0; id_memwrite = 0; id_memtoreg = 0;
    endtask

    initial begin
        rst = 1; stall = 0; flush = 0;
        id_clear();
        mem_regwrite = 0; mem_rd = 0; mem_result = 0;
        wb_regwrite = 0; wb_rd = 0; wb_result = 0;

        // Reset
        step(); step();
        chk("rst_valid", 32'(ex_valid), 0);
        chk("rst_aluctrl", 32'(aluctrl), 32'h2);
        chk("rst_din1", din1, 0);
        chk("rst_dreg", dreg, 0);
        chk("rst_dext", dext, 0);
        chk("rst_hazard", 32'(hazard_stall), 0);
        chk("rst_ctrl", {27'd0, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, alusrc}, 0);
        rst = 0;

        // Plain capture
        id_valid = 1; id_rs = 1; id_rt = 2; id_rd = 3;
        id_rdata1 = 32'h10; id_rdata2 = 32'h20; id_imm = 32'h4;
        id_aluctrl = 3'h2; id_alusrc = 1; id_regwrite = 1;
        step();
        chk("plain_din1", din1, 32'h10);
        chk("plain_dreg", dreg, 32'h20);
        chk("plain_dext", dext, 32'h4);
        chk("plain_alusrc", 32'(alusrc), 1);
        chk("plain_valid", 32'(ex_valid), 1);
        chk("plain_rd", 32'(ex_rd), 3);

        // Forwarding priority
        id_rs = 3; id_rt = 4; id_rdata1 = 0; id_rdata2 = 32'h44; id_alusrc = 0;
        step();
        mem_regwrite = 1; mem_rd = 3; mem_result = 32'hAA;
        wb_regwrite = 1; wb_rd = 3; wb_result = 32'hBB;
        #1;
        chk("fwd_mem", din1, 32'hAA);
        chk("fwd_nomatch_rt", dreg, 32'h44);
        mem_regwrite = 0; #1;
        chk("fwd_wb", din1, 32'hBB);
        mem_regwrite = 1; mem_rd = 0; wb_rd = 0; #1;
        chk("fwd_rd0", din1, 32'h0);
        mem_rd = 4; #1;
        chk("fwd_mem_rt", dreg, 32'hAA);
        mem_regwrite = 0; mem_rd = 0; wb_regwrite = 0; wb_rd = 0;

        // Load-use hazard
        id_clear();
        id_valid = 1; id_rd = 5; id_memread = 1; id_regwrite = 1; id_memtoreg = 1;
        step();
        id_clear();
        id_valid = 1; id_rs = 5; id_rt = 6; id_rd = 7; id_rdata1 = 32'h55;
        id_regwrite = 1; id_aluctrl = 3'h0;
        #1;
        chk("lu_hazard", 32'(hazard_stall), 1);
        step();
        chk("lu_bubble_valid", 32'(ex_valid), 0);
        chk("lu_bubble_regwrite", 32'(ex_regwrite), 0);
        chk("lu_bubble_aluctrl", 32'(aluctrl), 32'h2);
        chk("lu_hazard_clear", 32'(hazard_stall), 0);
        step();
        chk("lu_load_valid", 32'(ex_valid), 1);
        chk("lu_load_din1", din1, 32'h55);
        chk("lu_load_aluctrl", 32'(aluctrl), 0);

        // Stall with flush holds
        stall = 1; flush = 1; id_rdata1 = 32'h99; id_rd = 9;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_din1", din1, 32'h55);
            chk("stall_rd", 32'(ex_rd), 7);
            chk("stall_valid", 32'(ex_valid), 1);
        end
        stall = 0;
        step();
        chk("flush_valid", 32'(ex_valid), 0);
        chk("flush_regwrite", 32'(ex_regwrite), 0);
        chk("flush_din1", din1, 0);
        flush = 0;

        // Store data forwarding
        id_clear();
        id_valid = 1; id_rt = 7; id_memwrite = 1; id_alusrc = 1; id_imm = 32'h8;
        step();
        wb_regwrite = 1; wb_rd = 7; wb_result = 32'h1234; #1;
        chk("st_dreg", dreg, 32'h1234);
        chk("st_dext", dext, 32'h8);
        chk("st_memwrite", 32'(ex_memwrite), 1);
        wb_regwrite = 0; wb_rd = 0;

        // rt-only hazard, then reset mid-hazard
        id_clear();
        id_valid = 1; id_rd = 9; id_memread = 1;
        step();
        id_clear();
        id_valid = 1; id_rs = 1; id_rt = 9;
        #1;
        chk("rt_hazard", 32'(hazard_stall), 1);
        rst = 1;
        step();
        chk("rsthz_hazard", 32'(hazard_stall), 0);
        chk("rsthz_valid", 32'(ex_valid), 0);
        chk("rsthz_memread", 32'(ex_memread), 0);
        rst = 0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
